// File: rtl/hazard_scoreboard_if.sv
// Issue-hazard interface between the decode stage and the hazard scoreboard.
// master: decode/issue side (drives the D-stage instruction and pipeline controls)
// slave : hazard_scoreboard (returns stall/issue, var-lat busy and pending mask)
//
// Handshake: issue_valid_i offers the D instruction every cycle it is present.
// The instruction is consumed on a rising edge exactly when issue_o is 1 in the
// cycle before it; while stall_o is 1 the producer must hold all D fields
// stable. issue_o and stall_o are never both 1, and flush_i drops the offer.
interface hazard_scoreboard_if #(
  parameter int NREG = 32,
  parameter int RW   = 5,
  parameter int LW   = 3
);
  logic            issue_valid_i;
  logic [RW-1:0]   rs_i;
  logic [RW-1:0]   rt_i;
  logic            rs_used_i;
  logic            rt_used_i;
  logic [RW-1:0]   rd_i;
  logic            rd_wen_i;
  logic [LW-1:0]   lat_i;
  logic            varlat_i;
  logic            varlat_done_i;
  logic            ext_stall_i;
  logic            flush_i;
  logic            stall_o;
  logic            issue_o;
  logic            varlat_busy_o;
  logic [NREG-1:0] pend_o;

  modport master (
    output issue_valid_i, rs_i, rt_i, rs_used_i, rt_used_i, rd_i, rd_wen_i,
           lat_i, varlat_i, varlat_done_i, ext_stall_i, flush_i,
    input  stall_o, issue_o, varlat_busy_o, pend_o
  );

  modport slave (
    input  issue_valid_i, rs_i, rt_i, rs_used_i, rt_used_i, rd_i, rd_wen_i,
           lat_i, varlat_i, varlat_done_i, ext_stall_i, flush_i,
    output stall_o, issue_o, varlat_busy_o, pend_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based issue-hazard unit sitting at the D->E boundary.
// Tracks in-flight destination registers: fixed-latency producers count down
// per register, one variable-latency producer (div/mul) is released by
// varlat_done_i. Gates issue on RAW / WAW / structural hazards, freezes on a
// downstream stall and clears completely on an exception flush.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   sb       : hazard_scoreboard_if.slave (D instruction in, stall/issue/status out)
module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int RW      = 5,
  parameter int MAX_LAT = 7,
  parameter int LW      = 3
) (
  input  logic                clk,
  input  logic                rst,
  hazard_scoreboard_if.slave  sb
);

  logic [NREG-1:0] pend_q, pend_d;
  logic [NREG-1:0] vl_q, vl_d;
  logic [LW-1:0]   cnt_q [NREG];
  logic [LW-1:0]   cnt_d [NREG];
  logic            varlat_busy_q, varlat_busy_d;
  logic [RW-1:0]   vl_rd_q, vl_rd_d;

  logic raw, waw, str, stall, issue;

  // Hazards look only at registered state: a register clearing at the coming
  // edge still stalls this cycle.
  always_comb begin
    raw   = (sb.rs_used_i & pend_q[sb.rs_i]) | (sb.rt_used_i & pend_q[sb.rt_i]);
    // A later write may overtake an in-flight fixed one only if it completes
    // no earlier; a var-lat owner can never be overtaken.
    waw   = sb.rd_wen_i & pend_q[sb.rd_i] &
            (vl_q[sb.rd_i] | (cnt_q[sb.rd_i] > sb.lat_i));
    str   = sb.varlat_i & varlat_busy_q;
    stall = sb.issue_valid_i & (raw | waw | str | sb.ext_stall_i) & ~sb.flush_i;
    issue = sb.issue_valid_i & ~stall & ~sb.ext_stall_i & ~sb.flush_i;
  end

  always_comb begin
    pend_d        = pend_q;
    vl_d          = vl_q;
    cnt_d         = cnt_q;
    varlat_busy_d = varlat_busy_q;
    vl_rd_d       = vl_rd_q;
    if (sb.flush_i) begin
      pend_d        = '0;
      vl_d          = '0;
      varlat_busy_d = 1'b0;
      vl_rd_d       = '0;
      for (int r = 0; r < NREG; r++) cnt_d[r] = '0;
    end else begin
      if (!sb.ext_stall_i) begin
        for (int r = 1; r < NREG; r++) begin
          if (!vl_q[r] && cnt_q[r] != '0) begin
            cnt_d[r] = cnt_q[r] - LW'(1);
            if (cnt_q[r] == LW'(1)) pend_d[r] = 1'b0;
          end
        end
      end
      // Completion of the variable-latency unit is honoured even when frozen.
      if (sb.varlat_done_i && varlat_busy_q) begin
        pend_d[vl_rd_q] = 1'b0;
        vl_d[vl_rd_q]   = 1'b0;
        varlat_busy_d   = 1'b0;
      end
      // New entry is applied last so a set beats a same-cycle clear.
      if (issue) begin
        if (sb.rd_wen_i && sb.rd_i != '0) begin
          pend_d[sb.rd_i] = 1'b1;
          if (sb.varlat_i) begin
            vl_d[sb.rd_i]  = 1'b1;
            cnt_d[sb.rd_i] = '0;
            varlat_busy_d  = 1'b1;
            vl_rd_d        = sb.rd_i;
          end else begin
            vl_d[sb.rd_i]  = 1'b0;
            cnt_d[sb.rd_i] = sb.lat_i;
          end
        end else if (sb.varlat_i) begin
          // No register to release later; point the owner at r0 so a
          // completion cannot clear an unrelated entry.
          varlat_busy_d = 1'b1;
          vl_rd_d       = '0;
        end
      end
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q        <= '0;
      vl_q          <= '0;
      varlat_busy_q <= 1'b0;
      vl_rd_q       <= '0;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      pend_q        <= pend_d;
      vl_q          <= vl_d;
      varlat_busy_q <= varlat_busy_d;
      vl_rd_q       <= vl_rd_d;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    sb.stall_o       = stall;
    sb.issue_o       = issue;
    sb.varlat_busy_o = varlat_busy_q;
    sb.pend_o        = {pend_q[NREG-1:1], 1'b0};
  end

  // A fixed producer must report a latency in 1..MAX_LAT.
  a_lat_legal: assert property (@(posedge clk) disable iff (rst)
    (issue && sb.rd_wen_i && !sb.varlat_i && sb.rd_i != '0) |->
      (sb.lat_i != '0 && {1'b0, sb.lat_i} <= (LW+1)'(MAX_LAT)));

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int NREG = 32;
  localparam int RW   = 5;
  localparam int LW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  hazard_scoreboard_if #(.NREG(NREG), .RW(RW), .LW(LW)) sb_if ();

  hazard_scoreboard #(.NREG(NREG), .RW(RW), .MAX_LAT(7), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Time is measured in "advancing edges" (edges with neither flush nor
  // ext_stall). A fixed producer is pending until adv reaches its ready
  // point; the var-lat owner is pending until it completes.
  int ready_adv [NREG];
  int adv     = 0;
  int var_reg = -1;
  bit busy    = 1'b0;

  function automatic bit m_pend(int r);
    return (r != 0) && ((ready_adv[r] > adv) || (r == var_reg));
  endfunction

  function automatic int m_remaining(int r);
    return (ready_adv[r] > adv) ? ready_adv[r] - adv : 0;
  endfunction

  function automatic bit m_stall();
    bit raw, waw, str;
    int rd;
    rd  = int'(sb_if.rd_i);
    raw = (sb_if.rs_used_i && m_pend(int'(sb_if.rs_i))) ||
          (sb_if.rt_used_i && m_pend(int'(sb_if.rt_i)));
    waw = sb_if.rd_wen_i && m_pend(rd) &&
          ((rd == var_reg) || (m_remaining(rd) > int'(sb_if.lat_i)));
    str = sb_if.varlat_i && busy;
    return sb_if.issue_valid_i && !sb_if.flush_i &&
           (raw || waw || str || sb_if.ext_stall_i);
  endfunction

  function automatic bit m_issue();
    return sb_if.issue_valid_i && !sb_if.flush_i && !sb_if.ext_stall_i && !m_stall();
  endfunction

  function automatic logic [NREG-1:0] m_pend_vec();
    logic [NREG-1:0] v;
    v = '0;
    for (int r = 0; r < NREG; r++) v[r] = m_pend(r);
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) ready_adv[r] = 0;
      adv = 0; var_reg = -1; busy = 1'b0;
    end else if (sb_if.flush_i) begin
      for (int r = 0; r < NREG; r++) ready_adv[r] = 0;
      adv = 0; var_reg = -1; busy = 1'b0;
    end else begin
      bit iss;
      iss = m_issue();
      if (!sb_if.ext_stall_i) adv = adv + 1;
      if (sb_if.varlat_done_i && busy) begin
        var_reg = -1;
        busy    = 1'b0;
      end
      if (iss) begin
        if (sb_if.rd_wen_i && sb_if.rd_i != '0) begin
          if (sb_if.varlat_i) begin
            var_reg = int'(sb_if.rd_i);
            ready_adv[sb_if.rd_i] = 0;
            busy = 1'b1;
          end else begin
            ready_adv[sb_if.rd_i] = adv + int'(sb_if.lat_i);
          end
        end else if (sb_if.varlat_i) begin
          busy = 1'b1;
        end
      end
    end
  end

  // ---------------- compare process (every cycle) ----------------
  always @(negedge clk) begin
    logic [NREG-1:0] exp_pend;
    exp_pend = m_pend_vec();
    checks += 4;
    if (sb_if.stall_o !== m_stall()) begin
      errors++;
      $display("FAIL model_stall t=%0t got=%b want=%b", $time, sb_if.stall_o, m_stall());
    end
    if (sb_if.issue_o !== m_issue()) begin
      errors++;
      $display("FAIL model_issue t=%0t got=%b want=%b", $time, sb_if.issue_o, m_issue());
    end
    if (sb_if.varlat_busy_o !== busy) begin
      errors++;
      $display("FAIL model_busy t=%0t got=%b want=%b", $time, sb_if.varlat_busy_o, busy);
    end
    if (sb_if.pend_o !== exp_pend) begin
      errors++;
      $display("FAIL model_pend t=%0t got=%h want=%h", $time, sb_if.pend_o, exp_pend);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    sb_if.issue_valid_i = 1'b0;
    sb_if.rs_i = '0; sb_if.rt_i = '0;
    sb_if.rs_used_i = 1'b0; sb_if.rt_used_i = 1'b0;
    sb_if.rd_i = '0; sb_if.rd_wen_i = 1'b0;
    sb_if.lat_i = LW'(1);
    sb_if.varlat_i = 1'b0;
    sb_if.varlat_done_i = 1'b0;
    sb_if.ext_stall_i = 1'b0;
    sb_if.flush_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic producer(input int rd, input int lat, input bit var_lat);
    idle();
    sb_if.issue_valid_i = 1'b1;
    sb_if.rd_i     = RW'(rd);
    sb_if.rd_wen_i = 1'b1;
    sb_if.lat_i    = LW'(lat);
    sb_if.varlat_i = var_lat;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pend", sb_if.pend_o, 32'h0);
    chk("reset_busy", 32'(sb_if.varlat_busy_o), 32'h0);
    chk("reset_stall", 32'(sb_if.stall_o), 32'h0);
    rst = 1'b0;
    step();

    // 1: RAW on a lat=3 producer: 3 stall cycles, issue on the 4th
    producer(5, 3, 1'b0);
    @(negedge clk); chk("t1_prod_issue", 32'(sb_if.issue_o), 32'h1);
    step();
    idle();
    sb_if.issue_valid_i = 1'b1; sb_if.rs_i = 5'd5; sb_if.rs_used_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("t1_raw_stall", 32'(sb_if.stall_o), 32'h1);
      step();
    end
    @(negedge clk);
    chk("t1_dep_issue", 32'(sb_if.issue_o), 32'h1);
    chk("t1_pend5_clear", 32'(sb_if.pend_o[5]), 32'h0);
    step(); idle();

    // 2: r0 destination is never tracked
    producer(0, 5, 1'b0);
    @(negedge clk); chk("t2_prod_issue", 32'(sb_if.issue_o), 32'h1);
    step();
    idle();
    sb_if.issue_valid_i = 1'b1; sb_if.rs_i = 5'd0; sb_if.rs_used_i = 1'b1;
    @(negedge clk);
    chk("t2_pend_zero", sb_if.pend_o, 32'h0);
    chk("t2_dep_issue", 32'(sb_if.issue_o), 32'h1);
    step(); idle();

    // 3: variable-latency producer and structural hazard
    producer(8, 1, 1'b1);
    @(negedge clk); chk("t3_div_issue", 32'(sb_if.issue_o), 32'h1);
    step();
    idle();
    sb_if.issue_valid_i = 1'b1; sb_if.rt_i = 5'd8; sb_if.rt_used_i = 1'b1;
    @(negedge clk);
    chk("t3_busy", 32'(sb_if.varlat_busy_o), 32'h1);
    chk("t3_pend8", 32'(sb_if.pend_o[8]), 32'h1);
    chk("t3_raw_stall_a", 32'(sb_if.stall_o), 32'h1);
    step();
    sb_if.varlat_done_i = 1'b1;
    @(negedge clk); chk("t3_raw_stall_done", 32'(sb_if.stall_o), 32'h1);
    step();
    sb_if.varlat_done_i = 1'b0;
    @(negedge clk);
    chk("t3_dep_issue", 32'(sb_if.issue_o), 32'h1);
    chk("t3_busy_clear", 32'(sb_if.varlat_busy_o), 32'h0);
    step();
    producer(10, 1, 1'b1);
    @(negedge clk); chk("t3_div2_issue", 32'(sb_if.issue_o), 32'h1);
    step();
    producer(11, 1, 1'b1);
    @(negedge clk); chk("t3_str_stall", 32'(sb_if.stall_o), 32'h1);
    step();
    sb_if.varlat_done_i = 1'b1;
    @(negedge clk); chk("t3_str_stall_done", 32'(sb_if.stall_o), 32'h1);
    step();
    sb_if.varlat_done_i = 1'b0;
    @(negedge clk); chk("t3_div3_issue", 32'(sb_if.issue_o), 32'h1);
    step();
    idle(); sb_if.varlat_done_i = 1'b1;
    step();
    sb_if.varlat_done_i = 1'b0;
    @(negedge clk);
    chk("t3_final_busy", 32'(sb_if.varlat_busy_o), 32'h0);
    chk("t3_final_pend", sb_if.pend_o, 32'h0);
    step();

    // 4: ext_stall freezes the countdown
    producer(4, 2, 1'b0);
    @(negedge clk); chk("t4_prod_issue", 32'(sb_if.issue_o), 32'h1);
    step();
    idle();
    sb_if.issue_valid_i = 1'b1; sb_if.rs_i = 5'd4; sb_if.rs_used_i = 1'b1;
    sb_if.ext_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_frozen_pend4", 32'(sb_if.pend_o[4]), 32'h1);
      chk("t4_frozen_stall", 32'(sb_if.stall_o), 32'h1);
      step();
    end
    sb_if.ext_stall_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk("t4_post_stall", 32'(sb_if.stall_o), 32'h1);
      step();
    end
    @(negedge clk); chk("t4_dep_issue", 32'(sb_if.issue_o), 32'h1);
    step(); idle();

    // 5: flush clears everything, drops the same-cycle issue
    producer(3, 4, 1'b0);
    @(negedge clk); chk("t5_r3_issue", 32'(sb_if.issue_o), 32'h1);
    step();
    producer(9, 1, 1'b1);
    @(negedge clk); chk("t5_r9_issue", 32'(sb_if.issue_o), 32'h1);
    step();
    producer(12, 1, 1'b0);
    sb_if.flush_i = 1'b1;
    @(negedge clk);
    chk("t5_pend_before", sb_if.pend_o, 32'h0000_0208);
    chk("t5_flush_no_issue", 32'(sb_if.issue_o), 32'h0);
    chk("t5_flush_no_stall", 32'(sb_if.stall_o), 32'h0);
    step(); idle();
    @(negedge clk);
    chk("t5_pend_cleared", sb_if.pend_o, 32'h0);
    chk("t5_busy_cleared", 32'(sb_if.varlat_busy_o), 32'h0);
    step();
    sb_if.varlat_done_i = 1'b1;
    step();
    sb_if.varlat_done_i = 1'b0;
    @(negedge clk);
    chk("t5_late_done_busy", 32'(sb_if.varlat_busy_o), 32'h0);
    chk("t5_late_done_pend", sb_if.pend_o, 32'h0);
    step();

    // 6: WAW against a longer in-flight write, then async reset
    producer(6, 5, 1'b0);
    @(negedge clk); chk("t6_prod_issue", 32'(sb_if.issue_o), 32'h1);
    step();
    producer(6, 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t6_waw_stall", 32'(sb_if.stall_o), 32'h1);
      step();
    end
    @(negedge clk); chk("t6_waw_issue", 32'(sb_if.issue_o), 32'h1);
    step(); idle();
    producer(6, 5, 1'b0);
    @(negedge clk); chk("t6_prod2_issue", 32'(sb_if.issue_o), 32'h1);
    step(); idle();
    step();
    @(negedge clk); chk("t6_pend6_mid", 32'(sb_if.pend_o[6]), 32'h1);
    #2 rst = 1'b1;
    #1 chk("t6_async_reset_pend", sb_if.pend_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    @(negedge clk); chk("t6_after_reset_pend", sb_if.pend_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
